rr_arb_stage: RTL and testbench
===============================

Name: rr_arb_stage

Overview:
- N-requester round-robin arbiter with a single registered output stage.
- Each requester presents `valid` + data.
- One winner per cycle is loaded into the output register, tagged with its binary index.
- Shares one downstream consumer (e.g. a bus port or a shared datapath) between N producers at full throughput.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..64.
- DATA_WIDTH, 32, payload width per requester.
- IDX_WIDTH, (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ), index width; derived, do not override.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  packed payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  output  NUM_REQ  one-hot-or-zero accept strobe per requester.
- out_valid_o  output  1  output register holds a transfer.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  DATA_WIDTH  registered payload.
- out_idx_o  output  IDX_WIDTH  registered binary index of the source requester.
- out_gnt_o  output  NUM_REQ  registered one-hot form of out_idx_o.

Behaviour:
- Reset (rst_i high at an edge):
  - out_valid_o=0, out_data_o=0, out_idx_o=0, out_gnt_o=0, priority pointer ptr=0.
  - Any held transfer is discarded.
  - req_ready_o is held 0 combinationally while rst_i=1.
- load = !out_valid_o || out_ready_i (stage empty or draining this cycle).
- Arbitration (combinational):
  - Search requesters ptr, ptr+1, …, NUM_REQ-1, then 0, …, ptr-1, modulo NUM_REQ.
  - The first k with req_valid_i[k]=1 wins; win is one-hot or zero.
- req_ready_o = win & {NUM_REQ{load}}. At most one bit set. This is zero-cycle combinational from req_valid_i and out_ready_i.
- On an edge with load=1 and win≠0:
  - out_valid_o←1; out_data_o←req_data_i[k]; out_idx_o←k; out_gnt_o←win.
  - ptr←(k+1) mod NUM_REQ; wrap from NUM_REQ-1 goes to 0.
- On an edge with load=1 and win=0:
  - out_valid_o←0.
  - Data, idx and gnt registers hold their old value (don't-care).
  - ptr unchanged.
- On an edge with load=0: all registers hold.
- Output rules:
  - out_valid_o and out_data_o/out_idx_o/out_gnt_o are stable while out_valid_o=1 and out_ready_i=0.
  - out_valid_o never drops without a handshake, except on reset.
- Latency: 1 cycle from accept (req_valid & req_ready) to out_valid_o.
- Throughput: 1 transfer per cycle when out_ready_i is held high.
- Upstream contract: req_valid_i[k] and its data are held until req_ready_o[k]. The arbiter does not latch unaccepted requests.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,… A requester waits at most NUM_REQ-1 accepts.
- out_ready_i while out_valid_o=0 has no effect beyond enabling load.
- NUM_REQ=1: ptr stays 0; out_idx_o=0; the block degenerates to a pipeline register.

Optional Feature:
- Macro: RR_ARB_STAGE_ASSERT_EN.
- Defined: simulation-only concurrent assertions, disabled during rst_i.
  - $onehot0(req_ready_o).
  - $onehot(out_gnt_o) whenever out_valid_o.
  - out_gnt_o[out_idx_o]=1 whenever out_valid_o.
  - Output stability under backpressure.
  - Upstream-hold rule: req_valid_i[k] & !req_ready_o[k] implies req_valid_i[k] in the next cycle.
  - Any failure calls $error with the module name.
- Undefined: no assertion code is compiled; RTL behaviour is identical.

Decomposition:
- Package rr_arb_pkg:
  - function idx_width(n) returning (n==1)?1:$clog2(n).
  - function rotate_pick(req, ptr) returning the one-hot winner, for reuse by the bench model.
- Sub-module rr_prio_select:
  - Combinational; inputs req and ptr; outputs win (one-hot-or-zero) and win_idx.
  - Implemented as a double-width masked priority search.
  - The top level holds only the registers and the handshake logic.

Test Plan:
- Reset mid-transfer: NUM_REQ=4, out_valid_o=1, out_ready_i=0, assert rst_i for 1 cycle -> next cycle out_valid_o=0, ptr=0, req_ready_o=0 during reset.
- Full rotation: all 4 valid, out_ready_i=1 for 8 cycles -> out_idx_o sequence 0,1,2,3,0,1,2,3; each req_ready_o bit high exactly 2 cycles.
- Backpressure: req 2 valid with data 0xA5, out_ready_i=0 for 3 cycles -> out_valid_o=1 and out_data_o=0xA5 stable; req_ready_o=0 after first accept; one transfer only after out_ready_i rises.
- Pointer wrap/skip: ptr=3 (after granting 2), valid={0,1} only -> req 0 granted, then req 1; never req 0 twice in a row while 1 waits.
- Simultaneous drain and load: out_valid_o=1, out_ready_i=1, req 1 valid -> same edge completes old transfer and loads idx 1; out_valid_o stays 1 with no bubble.
- NUM_REQ=1: valid toggling 1,0,1 with out_ready_i=1 -> out_valid_o follows 1 cycle later; out_idx_o=0, out_gnt_o=1.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter stage: index-width derivation
// and a reference rotate-and-pick winner function.
package rr_arb_pkg;

  localparam int MAX_REQ = 64;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int idx_width(input int n);
    return (n == 1) ? 1 : $clog2(n);
  endfunction

  // One-hot winner of a circular search starting at ptr over the low n bits.
  function automatic logic [MAX_REQ-1:0] rotate_pick(input logic [MAX_REQ-1:0] req,
                                                     input int n,
                                                     input int ptr);
    logic [MAX_REQ-1:0] win;
    int k;
    win = '0;
    for (int j = 0; j < n; j++) begin
      k = (ptr + j) % n;
      if (req[6'(k)] && (win == '0)) win[6'(k)] = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational round-robin priority select. The request vector is doubled:
// the low copy is masked to requesters at or above ptr, the high copy is the
// full vector, so the lowest set bit of the doubled vector is the first
// requester found searching ptr, ptr+1, ... with wrap-around.
module rr_prio_select
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   win,
  output logic [IDX_WIDTH-1:0] win_idx
);

  logic [NUM_REQ-1:0]   mask;
  logic [2*NUM_REQ-1:0] dbl;

  // Thermometer mask keeping only requesters at or above the pointer.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(ptr));
    end
  end

  assign dbl = {req, req & mask};

  // Lowest set bit of the doubled vector, folded back into requester range.
  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (dbl[i]) begin
        win              = '0;
        win[i % NUM_REQ] = 1'b1;
        win_idx          = IDX_WIDTH'(i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/rr_arb_stage.sv
// N-requester round-robin arbiter feeding a single registered output stage.
// Optional simulation-only protocol assertions are compiled in when the
// RR_ARB_STAGE_ASSERT_EN macro is defined.
module rr_arb_stage
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = idx_width(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [IDX_WIDTH-1:0]          out_idx_o,
  output logic [NUM_REQ-1:0]            out_gnt_o
);

  logic [IDX_WIDTH-1:0]  ptr;
  logic [IDX_WIDTH-1:0]  ptr_next;
  logic [NUM_REQ-1:0]    win;
  logic [IDX_WIDTH-1:0]  win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  load;

  rr_prio_select #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_sel (
    .req     (req_valid_i),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // The stage can take a new word when it is empty or being drained now.
  assign load        = !out_valid_o || out_ready_i;
  assign req_ready_o = rst_i ? '0 : (win & {NUM_REQ{load}});
  assign ptr_next    = (win_idx == IDX_WIDTH'(NUM_REQ-1)) ? '0 : win_idx + IDX_WIDTH'(1);

  // Payload mux steered by the one-hot winner.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win[k]) win_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output register and priority pointer, advanced only when a winner loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_idx_o   <= '0;
      out_gnt_o   <= '0;
      ptr         <= '0;
    end else if (load) begin
      if (win != '0) begin
        out_valid_o <= 1'b1;
        out_data_o  <= win_data;
        out_idx_o   <= win_idx;
        out_gnt_o   <= win;
        ptr         <= ptr_next;
      end else begin
        out_valid_o <= 1'b0;
      end
    end
  end

`ifdef RR_ARB_STAGE_ASSERT_EN
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o))
    else $error("%m: req_ready_o is not one-hot-or-zero");

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> $onehot(out_gnt_o))
    else $error("%m: out_gnt_o is not one-hot while out_valid_o");

  a_gnt_matches_idx: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> out_gnt_o[out_idx_o])
    else $error("%m: out_gnt_o does not match out_idx_o");

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o) &&
                                        $stable(out_idx_o) && $stable(out_gnt_o)))
    else $error("%m: output changed under backpressure");

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
    a_upstream_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[g] && !req_ready_o[g]) |=> req_valid_i[g])
      else $error("%m: requester dropped valid before being accepted");
  end
`endif

endmodule

// File: tb/tb_rr_arb_stage.sv
// Self-checking bench for rr_arb_stage: a 4-requester and a 1-requester
// instance run side by side against a circular-search reference model,
// with directed scenarios followed by randomized traffic.
module tb_rr_arb_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid4;
  logic [31:0] req_data4;
  logic [3:0]  req_ready4;
  logic        out_valid4;
  logic        out_ready4;
  logic [7:0]  out_data4;
  logic [1:0]  out_idx4;
  logic [3:0]  out_gnt4;

  logic        req_valid1;
  logic [7:0]  req_data1;
  logic        req_ready1;
  logic        out_valid1;
  logic        out_ready1;
  logic [7:0]  out_data1;
  logic        out_idx1;
  logic        out_gnt1;

  int n_compared = 0;
  int n_mismatch = 0;

  // Reference model state: [0] = 4-requester instance, [1] = 1-requester.
  logic       m_valid [2] = '{1'b0, 1'b0};
  logic [7:0] m_data  [2] = '{8'h00, 8'h00};
  int         m_idx   [2] = '{0, 0};
  int         m_ptr   [2] = '{0, 0};
  logic [3:0] m_gnt4 = 4'b0000;
  logic       m_gnt1 = 1'b0;
  logic [3:0] exp_ready4 = 4'b0000;
  logic       exp_ready1 = 1'b0;
  int         w4, w1;
  logic       load4, load1;

  rr_arb_stage #(.NUM_REQ(4), .DATA_WIDTH(8)) dut4 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid4),
    .req_data_i  (req_data4),
    .req_ready_o (req_ready4),
    .out_valid_o (out_valid4),
    .out_ready_i (out_ready4),
    .out_data_o  (out_data4),
    .out_idx_o   (out_idx4),
    .out_gnt_o   (out_gnt4)
  );

  rr_arb_stage #(.NUM_REQ(1), .DATA_WIDTH(8)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid1),
    .req_data_i  (req_data1),
    .req_ready_o (req_ready1),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready1),
    .out_data_o  (out_data1),
    .out_idx_o   (out_idx1),
    .out_gnt_o   (out_gnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [3:0] v4, input logic [31:0] d4,
                               input logic rdy4, input logic v1, input logic [7:0] d1,
                               input logic rdy1);
    @(posedge clk);
    #1;
    rst        = r;
    req_valid4 = v4;
    req_data4  = d4;
    out_ready4 = rdy4;
    req_valid1 = v1;
    req_data1  = d1;
    out_ready1 = rdy1;
  endtask

  // First requester found searching ptr, ptr+1, ... modulo n; -1 if none.
  function automatic int pickWinner(input logic [3:0] v, input int n, input int ptr);
    int k;
    for (int j = 0; j < n; j++) begin
      k = (ptr + j) % n;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Every cycle: compare DUT against the model, then advance the model
  // by what the coming rising edge must do.
  always @(negedge clk) begin
    load4 = !m_valid[0] || out_ready4;
    load1 = !m_valid[1] || out_ready1;
    w4 = pickWinner(req_valid4, 4, m_ptr[0]);
    w1 = pickWinner({3'b000, req_valid1}, 1, m_ptr[1]);
    exp_ready4 = (!rst && load4 && w4 >= 0) ? 4'(1 << w4) : 4'b0000;
    exp_ready1 = !rst && load1 && w1 >= 0;

    checkOutput("ready4", 64'(req_ready4), 64'(exp_ready4));
    checkOutput("valid4", 64'(out_valid4), 64'(m_valid[0]));
    checkOutput("data4",  64'(out_data4),  64'(m_data[0]));
    checkOutput("idx4",   64'(out_idx4),   64'(m_idx[0]));
    checkOutput("gnt4",   64'(out_gnt4),   64'(m_gnt4));
    checkOutput("ready1", 64'(req_ready1), 64'(exp_ready1));
    checkOutput("valid1", 64'(out_valid1), 64'(m_valid[1]));
    checkOutput("data1",  64'(out_data1),  64'(m_data[1]));
    checkOutput("idx1",   64'(out_idx1),   64'(m_idx[1]));
    checkOutput("gnt1",   64'(out_gnt1),   64'(m_gnt1));

    if (rst) begin
      m_valid[0] = 1'b0; m_data[0] = 8'h00; m_idx[0] = 0; m_gnt4 = 4'b0000; m_ptr[0] = 0;
      m_valid[1] = 1'b0; m_data[1] = 8'h00; m_idx[1] = 0; m_gnt1 = 1'b0;    m_ptr[1] = 0;
    end else begin
      if (load4) begin
        if (w4 >= 0) begin
          m_valid[0] = 1'b1;
          m_data[0]  = req_data4[w4*8 +: 8];
          m_idx[0]   = w4;
          m_gnt4     = 4'(1 << w4);
          m_ptr[0]   = (w4 + 1) % 4;
        end else begin
          m_valid[0] = 1'b0;
        end
      end
      if (load1) begin
        if (w1 >= 0) begin
          m_valid[1] = 1'b1;
          m_data[1]  = req_data1;
          m_idx[1]   = 0;
          m_gnt1     = 1'b1;
          m_ptr[1]   = 0;
        end else begin
          m_valid[1] = 1'b0;
        end
      end
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    int         cnt [4];
    logic [3:0] nv;
    logic [31:0] nd;
    logic       nv1;
    logic [7:0] nd1;

    rst = 1'b1; req_valid4 = '0; req_data4 = '0; out_ready4 = 1'b0;
    req_valid1 = 1'b0; req_data1 = '0; out_ready1 = 1'b0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;

    // Reset, then confirm the idle reset state.
    applyStimulus(1, 4'b0000, 32'h0, 0, 0, 8'h00, 1);
    applyStimulus(1, 4'b0000, 32'h0, 0, 0, 8'h00, 1);
    applyStimulus(0, 4'b0000, 32'h0, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("rst_valid", 64'(out_valid4), 64'd0);
    checkOutput("rst_data",  64'(out_data4),  64'd0);
    checkOutput("rst_gnt",   64'(out_gnt4),   64'd0);

    // Full rotation with all four requesters continuously valid.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 4'b1111, 32'h13121110, 1, 0, 8'h00, 1);
      @(negedge clk);
      checkOutput("rot_ready", 64'(req_ready4), 64'(1 << (c % 4)));
      for (int k = 0; k < 4; k++) if (req_ready4[k]) cnt[k]++;
      if (c > 0) checkOutput("rot_idx", 64'(out_idx4), 64'((c - 1) % 4));
    end
    for (int k = 0; k < 4; k++) checkOutput("rot_count", 64'(cnt[k]), 64'd2);
    applyStimulus(0, 4'b0111, 32'h13121110, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("rot_idx_last", 64'(out_idx4), 64'd3);
    applyStimulus(0, 4'b0110, 32'h13121110, 1, 0, 8'h00, 1);
    applyStimulus(0, 4'b0100, 32'h13121110, 1, 0, 8'h00, 1);
    applyStimulus(0, 4'b0000, 32'h0, 1, 0, 8'h00, 1);

    // Backpressure on requester 2, with the single-requester stage toggling.
    applyStimulus(0, 4'b0100, 32'h00A50000, 0, 1, 8'h11, 1);
    @(negedge clk);
    checkOutput("bp_ready_first", 64'(req_ready4), 64'b0100);
    checkOutput("n1_ready", 64'(req_ready1), 64'd1);
    applyStimulus(0, 4'b0100, 32'h00330000, 0, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("bp_ready_stall", 64'(req_ready4), 64'd0);
    checkOutput("bp_data", 64'(out_data4), 64'hA5);
    checkOutput("n1_data", 64'(out_data1), 64'h11);
    checkOutput("n1_gnt",  64'(out_gnt1),  64'd1);
    applyStimulus(0, 4'b0100, 32'h00330000, 0, 1, 8'h22, 1);
    @(negedge clk);
    checkOutput("bp_data_hold", 64'(out_data4), 64'hA5);
    checkOutput("n1_bubble", 64'(out_valid1), 64'd0);
    applyStimulus(0, 4'b0100, 32'h00330000, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("bp_ready_release", 64'(req_ready4), 64'b0100);
    checkOutput("n1_data2", 64'(out_data1), 64'h22);
    applyStimulus(0, 4'b0000, 32'h0, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("bp_second", 64'(out_data4), 64'h33);

    // Pointer wrap from 3 and skip, then drain-and-load on the same edge.
    applyStimulus(0, 4'b0011, 32'h00000201, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("wrap_ready0", 64'(req_ready4), 64'b0001);
    applyStimulus(0, 4'b0011, 32'h00000201, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("wrap_ready1", 64'(req_ready4), 64'b0010);
    applyStimulus(0, 4'b0001, 32'h00000201, 1, 0, 8'h00, 1);
    applyStimulus(0, 4'b1000, 32'h77000000, 1, 0, 8'h00, 1);
    applyStimulus(0, 4'b0010, 32'h00008800, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("sim_ready", 64'(req_ready4), 64'b0010);
    checkOutput("sim_idx_old", 64'(out_idx4), 64'd3);
    applyStimulus(0, 4'b0000, 32'h0, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("sim_valid", 64'(out_valid4), 64'd1);
    checkOutput("sim_data",  64'(out_data4),  64'h88);

    // Reset while a transfer is held under backpressure.
    applyStimulus(0, 4'b0100, 32'h005C0000, 0, 0, 8'h00, 1);
    applyStimulus(0, 4'b0000, 32'h0, 0, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("mid_held", 64'(out_data4), 64'h5C);
    applyStimulus(1, 4'b1111, 32'h13121110, 0, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("mid_ready_in_rst", 64'(req_ready4), 64'd0);
    applyStimulus(0, 4'b1111, 32'h13121110, 1, 0, 8'h00, 1);
    @(negedge clk);
    checkOutput("mid_valid", 64'(out_valid4), 64'd0);
    checkOutput("mid_idx",   64'(out_idx4),   64'd0);
    checkOutput("mid_ptr",   64'(req_ready4), 64'b0001);

    // Randomized traffic honouring the hold-until-accepted upstream rule.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      #1;
      nv = '0;
      nd = req_data4;
      for (int k = 0; k < 4; k++) begin
        if (req_valid4[k] && !exp_ready4[k]) begin
          nv[k] = 1'b1;
        end else if ($urandom_range(0, 1) == 1) begin
          nv[k] = 1'b1;
          nd[k*8 +: 8] = 8'($urandom);
        end
      end
      if (req_valid1 && !exp_ready1) begin
        nv1 = 1'b1;
        nd1 = req_data1;
      end else begin
        nv1 = ($urandom_range(0, 1) == 1);
        nd1 = 8'($urandom);
      end
      applyStimulus(($urandom_range(0, 99) == 0), nv, nd, ($urandom_range(0, 3) != 0),
                    nv1, nd1, ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
